sdp_stream_reader: RTL and testbench

SDP_STREAM_READER -- requirements
Module: sdp_stream_reader

---
 rtl/sdp_stream_reader_if.sv | 24 ++
 rtl/sdp_stream_reader.sv | 196 +++++++++++++++++++
 tb/tb_sdp_stream_reader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdp_stream_reader_if.sv
// sdp_stream_reader_if: ready/valid stream carrying words out of the reader.
//   out_data  : stream word, head of the reader's output buffer
//   out_valid : out_data holds a word
//   out_ready : sink accepts; a word moves when out_valid and out_ready are both high
// Modports: master (reader side), slave (sink side).
interface sdp_stream_reader_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sdp_stream_reader.sv
// sdp_stream_reader: reads len consecutive words from a synchronous-read memory
// starting at base_addr and streams them out over a ready/valid interface.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request strobe, sampled only while idle
//   base_addr, len : request, latched on acceptance
//   busy           : high while a request is in progress
//   done / err     : one-cycle pulses on completion / rejection
//   addr_q, q      : memory read port (q valid one cycle after addr_q)
//   strm           : output stream (sdp_stream_reader_if.master)
// Build option: define SDP_STREAM_READER_WRAP_EN to let addresses wrap modulo
// DEPTH (err never pulses); otherwise requests running past DEPTH are rejected.
module sdp_stream_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [AW-1:0]                base_addr,
    input  logic [AW:0]                  len,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [AW-1:0]                addr_q,
    input  logic [WIDTH-1:0]             q,
    sdp_stream_reader_if.master          strm
);

    localparam logic [AW:0]   LenOne  = 1;
    localparam logic [AW-1:0] AddrOne = 1;
    localparam logic [AW-1:0] AddrMax = AW'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_d, addr_inc;
    logic [AW:0]      rem_q, rem_d;     // reads still to issue
    logic [AW:0]      xfer_q, xfer_d;   // words still to hand to the sink
    logic             p1_q, p1_d;       // read issued, memory sampling addr_q
    logic             p2_q;             // read data present on q this cycle
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             reject;

    // Output buffer: registered head word plus a two-entry FIFO behind it.
    logic [WIDTH-1:0] head_q, head_d;
    logic             hv_q, hv_d;
    logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
    logic [1:0]       fcnt_q, fcnt_d;

    logic             pop;
    logic             issue;
    logic [2:0]       credit;

    assign pop            = hv_q & strm.out_ready;
    assign strm.out_data  = head_q;
    assign strm.out_valid = hv_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign err            = err_q;

    // Words buffered plus words still in the memory pipeline.
    assign credit = 3'(hv_q) + 3'(fcnt_q) + 3'(p1_q) + 3'(p2_q);

    assign addr_inc = (addr_q == AddrMax) ? '0 : addr_q + AddrOne;

`ifdef SDP_STREAM_READER_WRAP_EN
    assign reject = 1'b0;
`else
    logic [AW+1:0] end_addr;
    assign end_addr = {2'b00, base_addr} + {1'b0, len};
    assign reject   = (end_addr > (AW+2)'(DEPTH));
`endif

    // Request sequencing and address generation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        xfer_d  = pop ? xfer_q - LenOne : xfer_q;
        p1_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        // Buffer is empty while idle, so the first read needs no credit check.
                        addr_d  = base_addr;
                        p1_d    = 1'b1;
                        rem_d   = len - LenOne;
                        xfer_d  = len;
                        state_d = (len == LenOne) ? StDrain : StRead;
                    end
                end
            end
            StRead: begin
                // Issue only if the word still fits when it lands two cycles later,
                // even if the sink stalls from now on.
                issue = (credit < 3'd3 + 3'(pop));
                if (issue) begin
                    addr_d = addr_inc;
                    p1_d   = 1'b1;
                    rem_d  = rem_q - LenOne;
                    if (rem_q == LenOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && (xfer_q == LenOne)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output buffer update: refill the head on pop or when empty, else queue q.
    always_comb begin
        logic [WIDTH-1:0] t0, t1;
        logic [1:0]       cnt_t;
        logic             push_fifo;
        head_d    = head_q;
        hv_d      = hv_q;
        t0        = s0_q;
        t1        = s1_q;
        cnt_t     = fcnt_q;
        push_fifo = p2_q;
        if (!hv_q || pop) begin
            if (fcnt_q != 2'd0) begin
                head_d = s0_q;
                hv_d   = 1'b1;
                t0     = s1_q;
                cnt_t  = fcnt_q - 2'd1;
            end else if (p2_q) begin
                head_d    = q;
                hv_d      = 1'b1;
                push_fifo = 1'b0;
            end else begin
                hv_d = 1'b0;
            end
        end
        if (push_fifo) begin
            if (cnt_t == 2'd0) begin
                t0 = q;
            end else begin
                t1 = q;
            end
            cnt_t = cnt_t + 2'd1;
        end
        s0_d   = t0;
        s1_d   = t1;
        fcnt_d = cnt_t;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            xfer_q  <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            head_q  <= '0;
            hv_q    <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            xfer_q  <= xfer_d;
            p1_q    <= p1_d;
            p2_q    <= p1_q;
            done_q  <= done_d;
            err_q   <= err_d;
            head_q  <= head_d;
            hv_q    <= hv_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_sdp_stream_reader.sv
// Directed self-checking bench for sdp_stream_reader (WIDTH=8, DEPTH=256, mem[a]=a).
module tb_sdp_stream_reader;
    localparam int W  = 8;
    localparam int D  = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, err;
    logic [AW-1:0] addr_q;
    logic [W-1:0]  q;
    logic [W-1:0]  mem [D];

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] rx[$];
    int done_cnt = 0;

    sdp_stream_reader_if #(.WIDTH(W)) strm_if ();

    sdp_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .addr_q    (addr_q),
        .q         (q),
        .strm      (strm_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) q <= mem[addr_q];

    // Inputs change just after posedge, so at negedge we see what the next edge transfers.
    always @(negedge clk) begin
        if (strm_if.out_valid && strm_if.out_ready) rx.push_back(strm_if.out_data);
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_rx(input string tag, input int first, input int n);
        chk({tag, "_count"}, 32'(rx.size()), 32'(n));
        for (int k = 0; k < n && k < rx.size(); k++) begin
            chk($sformatf("%s_word%0d", tag, k), 32'(rx[k]), 32'((first + k) % D));
        end
    endtask

    initial begin
        bit         pat [6];
        bit         stall;
        bit         seen;
        logic [7:0] held;
        int         d0;

        for (int i = 0; i < D; i++) mem[i] = W'(i);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        strm_if.out_ready = 1'b1;

        // Reset values
        #3 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valid", 32'(strm_if.out_valid), 32'd0);
        chk("rst_addr", 32'(addr_q), 32'd0);
        chk("rst_data", 32'(strm_if.out_data), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // A: base 3, len 4, sink always ready
        base_addr = 8'd3; len = 9'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("A_busy", 32'(busy), 32'd1);
        chk("A_addr_s1", 32'(addr_q), 32'd3);
        chk("A_valid_s1", 32'(strm_if.out_valid), 32'd0);
        tick();
        chk("A_valid_s2", 32'(strm_if.out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("A_valid_s%0d", k + 3), 32'(strm_if.out_valid), 32'd1);
            chk($sformatf("A_data_s%0d", k + 3), 32'(strm_if.out_data), 32'(3 + k));
            chk($sformatf("A_nodone_s%0d", k + 3), 32'(done), 32'd0);
        end
        tick();
        chk("A_done", 32'(done), 32'd1);
        chk("A_busy_fall", 32'(busy), 32'd0);
        chk("A_valid_end", 32'(strm_if.out_valid), 32'd0);
        tick();
        chk("A_done_pulse", 32'(done), 32'd0);
        check_rx("A", 3, 4);
        chk("A_done_cnt", 32'(done_cnt), 32'd1);

        // B: base 10, len 6, sink ready pattern 1,0,0,1,0,1,...
        rx.delete();
        d0 = done_cnt;
        base_addr = 8'd10; len = 9'd6; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            strm_if.out_ready = pat[i % 6];
            stall = strm_if.out_valid && !strm_if.out_ready;
            held  = strm_if.out_data;
            tick();
            if (stall) begin
                chk("B_hold_valid", 32'(strm_if.out_valid), 32'd1);
                chk("B_hold_data", 32'(strm_if.out_data), 32'(held));
            end
            if (done) seen = 1'b1;
        end
        chk("B_done_seen", 32'(seen), 32'd1);
        strm_if.out_ready = 1'b1;
        tick();
        check_rx("B", 10, 6);
        chk("B_done_cnt", 32'(done_cnt), 32'(d0 + 1));

        // C: len 0 -> immediate done, nothing read
        rx.delete();
        base_addr = 8'd100; len = 9'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("C_done", 32'(done), 32'd1);
        chk("C_busy", 32'(busy), 32'd0);
        chk("C_addr", 32'(addr_q), 32'd15);
        chk("C_valid", 32'(strm_if.out_valid), 32'd0);
        tick();
        chk("C_done_pulse", 32'(done), 32'd0);
        chk("C_valid2", 32'(strm_if.out_valid), 32'd0);
        chk("C_rx", 32'(rx.size()), 32'd0);

        // D: base 254, len 4 crosses the top of memory
        rx.delete();
        base_addr = 8'd254; len = 9'd4; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SDP_STREAM_READER_WRAP_EN
        chk("D_busy", 32'(busy), 32'd1);
        chk("D_err", 32'(err), 32'd0);
        wait_done("D_done_seen", 40);
        tick();
        check_rx("D", 254, 4);
`else
        chk("D_err", 32'(err), 32'd1);
        chk("D_busy", 32'(busy), 32'd0);
        chk("D_done", 32'(done), 32'd0);
        chk("D_addr", 32'(addr_q), 32'd15);
        tick();
        chk("D_err_pulse", 32'(err), 32'd0);
        chk("D_busy2", 32'(busy), 32'd0);
        chk("D_valid", 32'(strm_if.out_valid), 32'd0);
`endif

        // D2: base 252, len 4 ends exactly at DEPTH and is accepted
        rx.delete();
        base_addr = 8'd252; len = 9'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("D2_busy", 32'(busy), 32'd1);
        chk("D2_err", 32'(err), 32'd0);
        chk("D2_addr", 32'(addr_q), 32'd252);
        wait_done("D2_done_seen", 40);
        tick();
        check_rx("D2", 252, 4);

        // E: reset after the second word of an 8-word request
        rx.delete();
        base_addr = 8'd20; len = 9'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && rx.size() < 2; i++) tick();
        chk("E_two_words", 32'(rx.size()), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("E_rst_valid", 32'(strm_if.out_valid), 32'd0);
        chk("E_rst_busy", 32'(busy), 32'd0);
        chk("E_rst_done", 32'(done), 32'd0);
        chk("E_rst_addr", 32'(addr_q), 32'd0);
        chk("E_rst_data", 32'(strm_if.out_data), 32'd0);
        tick();
        chk("E_rst_held_valid", 32'(strm_if.out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        rx.delete();
        base_addr = 8'd0; len = 9'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("E_done_seen", 40);
        tick();
        check_rx("E", 0, 2);

        // F: second start while busy is ignored
        rx.delete();
        d0 = done_cnt;
        base_addr = 8'd40; len = 9'd3; start = 1'b1;
        tick();
        base_addr = 8'd50; len = 9'd2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("F_busy%0d", i), 32'(busy), 32'd1);
            tick();
        end
        start = 1'b0;
        wait_done("F_done_seen", 40);
        for (int i = 0; i < 4; i++) tick();
        check_rx("F", 40, 3);
        chk("F_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        chk("F_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
